// File: rtl/adder_aligner.sv
// Pre-addition exponent alignment: orders two unpacked operands and right-shifts the
// smaller significand by the exponent difference, SHIFT_STEP bits per cycle, with guard/round/sticky.
module adder_aligner #(
    parameter int X          = 32,
    parameter int expo_bits  = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [expo_bits-1:0]       exp_a,
    input  logic [X-expo_bits-1:0]     mant_a,
    input  logic [expo_bits-1:0]       exp_b,
    input  logic [X-expo_bits-1:0]     mant_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [expo_bits-1:0]       exp_out,
    output logic [X-expo_bits-1:0]     mant_big,
    output logic [X-expo_bits+2:0]     mant_small,
    output logic                       swapped
);

    localparam int M = X - expo_bits;
    localparam int W = M + 3;
    localparam logic [expo_bits-1:0] STEP_V  = expo_bits'(SHIFT_STEP);
    localparam logic [expo_bits:0]   FAR_LIM = (expo_bits + 1)'(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [expo_bits-1:0] exp_q, exp_d;
    logic [M-1:0]         big_q, big_d;
    logic [W-1:0]         small_q, small_d;
    logic                 swapped_q, swapped_d;
    logic [expo_bits-1:0] rem_q, rem_d;

    logic                 swap_s;
    logic [expo_bits-1:0] big_exp_s, small_exp_s, diff_s, k_s, rem_next_s;
    logic [M-1:0]         big_mant_s, small_mant_s;
    logic                 far_s;

    // Logical right shift by k; every bit leaving through the LSB is folded into sticky.
    function automatic logic [W-1:0] shr_sticky(input logic [W-1:0] v, input logic [expo_bits-1:0] k);
        logic [W-1:0] r;
        logic         lost;
        lost = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (j < int'(k)) begin
                lost = lost | v[j];
            end else begin
                lost = lost;
            end
        end
        r    = v >> k;
        r[0] = r[0] | lost;
        return r;
    endfunction

    // Operand ordering and exponent difference for the capture cycle.
    always_comb begin
        swap_s = (exp_b > exp_a) || ((exp_b == exp_a) && (mant_b > mant_a));
        if (swap_s) begin
            big_exp_s    = exp_b;
            small_exp_s  = exp_a;
            big_mant_s   = mant_b;
            small_mant_s = mant_a;
        end else begin
            big_exp_s    = exp_a;
            small_exp_s  = exp_b;
            big_mant_s   = mant_a;
            small_mant_s = mant_b;
        end
        diff_s = big_exp_s - small_exp_s;
        far_s  = ({1'b0, diff_s} >= FAR_LIM);
        if (rem_q > STEP_V) begin
            k_s = STEP_V;
        end else begin
            k_s = rem_q;
        end
        rem_next_s = rem_q - k_s;
    end

    // Next-state and next-output computation for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        exp_d       = exp_q;
        big_d       = big_q;
        small_d     = small_q;
        swapped_d   = swapped_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d      = big_exp_s;
                    big_d      = big_mant_s;
                    swapped_d  = swap_s;
                    in_ready_d = 1'b0;
                    if (diff_s == {expo_bits{1'b0}}) begin
                        small_d     = {small_mant_s, 3'b000};
                        rem_d       = {expo_bits{1'b0}};
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else if (far_s) begin
                        // Everything lands beyond the sticky position: only its OR survives.
                        small_d     = {{(W-1){1'b0}}, |small_mant_s};
                        rem_d       = {expo_bits{1'b0}};
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        small_d     = {small_mant_s, 3'b000};
                        rem_d       = diff_s;
                        state_d     = SHIFT;
                        out_valid_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                small_d = shr_sticky(small_q, k_s);
                rem_d   = rem_next_s;
                if (rem_next_s == {expo_bits{1'b0}}) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = SHIFT;
                    out_valid_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                rem_d       = {expo_bits{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            exp_q       <= {expo_bits{1'b0}};
            big_q       <= {M{1'b0}};
            small_q     <= {W{1'b0}};
            swapped_q   <= 1'b0;
            rem_q       <= {expo_bits{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            exp_q       <= exp_d;
            big_q       <= big_d;
            small_q     <= small_d;
            swapped_q   <= swapped_d;
            rem_q       <= rem_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign exp_out    = exp_q;
    assign mant_big   = big_q;
    assign mant_small = small_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_adder_aligner.sv
// Randomised and directed bench for adder_aligner against an arithmetic alignment model.
module tb_adder_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] mant_big;
    logic [26:0] mant_small;
    logic        swapped;

    int vectors = 0;
    int miscompares = 0;

    adder_aligner #(.X(32), .expo_bits(8), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .mant_a(mant_a), .exp_b(exp_b), .mant_b(mant_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small), .swapped(swapped)
    );

    always #5 clk = ~clk;

    // Reference: exact alignment of the smaller significand with sticky over all lost bits.
    function automatic void model(input logic [7:0] ea, input logic [23:0] ma,
                                  input logic [7:0] eb, input logic [23:0] mb,
                                  output logic sw, output logic [7:0] e,
                                  output logic [23:0] big, output logic [26:0] sm,
                                  output int lat);
        logic [23:0] smallm;
        logic [63:0] v, mask;
        int d;
        sw = (eb > ea) || ((eb == ea) && (mb > ma));
        e      = sw ? eb : ea;
        big    = sw ? mb : ma;
        smallm = sw ? ma : mb;
        d = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        if (d >= 27) begin
            sm  = {26'd0, |smallm};
            lat = 1;
        end else begin
            v    = {37'd0, smallm, 3'b000};
            mask = (64'd1 << d) - 64'd1;
            sm   = 27'(v >> d) | {26'd0, |(v & mask)};
            lat  = (d == 0) ? 1 : ((d + 3) / 4) + 1;
        end
    endfunction

    task automatic run_op(input logic [7:0] ea, input logic [23:0] ma,
                          input logic [7:0] eb, input logic [23:0] mb, input int stall,
                          output logic g_sw, output logic [7:0] g_e,
                          output logic [23:0] g_big, output logic [26:0] g_sm, output int g_lat);
        logic        x_sw;
        logic [7:0]  x_e;
        logic [23:0] x_big;
        logic [26:0] x_sm;
        int          x_lat;
        int          n;
        model(ea, ma, eb, mb, x_sw, x_e, x_big, x_sm, x_lat);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        out_ready = (stall == 0);
        exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_a = 8'($urandom); exp_b = 8'($urandom);
        mant_a = 24'($urandom); mant_b = 24'($urandom);
        g_lat = 1;
        while (!out_valid && g_lat < 40) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_in_ready: got %b want 0", in_ready);
            end
            @(posedge clk); #1; g_lat++;
        end
        g_sw = swapped; g_e = exp_out; g_big = mant_big; g_sm = mant_small;
        vectors++;
        if (out_valid !== 1'b1 || g_lat != x_lat) begin
            miscompares++;
            $display("FAIL latency: got valid=%b after %0d edges want valid=1 after %0d", out_valid, g_lat, x_lat);
        end
        vectors++;
        if ({swapped, exp_out, mant_big, mant_small} !== {x_sw, x_e, x_big, x_sm}) begin
            miscompares++;
            $display("FAIL result: got sw=%b e=%h big=%h sm=%h want sw=%b e=%h big=%h sm=%h",
                     swapped, exp_out, mant_big, mant_small, x_sw, x_e, x_big, x_sm);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            exp_a = 8'($urandom); mant_a = 24'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, exp_out, mant_big, mant_small, swapped} !== {2'b10, x_e, x_big, x_sm, x_sw}) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b r=%b sm=%h want v=1 r=0 sm=%h", out_valid, in_ready, mant_small, x_sm);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready, exp_out, mant_big, mant_small, swapped} !== {2'b01, x_e, x_big, x_sm, x_sw}) begin
            miscompares++;
            $display("FAIL consume: got v=%b r=%b e=%h sm=%h want v=0 r=1 e=%h sm=%h",
                     out_valid, in_ready, exp_out, mant_small, x_e, x_sm);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = 8'd0; exp_b = 8'd0; mant_a = 24'd0; mant_b = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, exp_out, mant_big, mant_small, swapped} !== {2'b10, 8'd0, 24'd0, 27'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got r=%b v=%b e=%h big=%h sm=%h sw=%b want r=1 v=0 all 0",
                     in_ready, out_valid, exp_out, mant_big, mant_small, swapped);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic sw; logic [7:0] e; logic [23:0] big; logic [26:0] sm; int lat;
        logic [7:0]  t_ea[5] = '{8'h80, 8'h7F, 8'h90, 8'hA8, 8'h9A};
        logic [23:0] t_ma[5] = '{24'hC00000, 24'h800000, 24'h800000, 24'hC00000, 24'hC00000};
        logic [7:0]  t_eb[5] = '{8'h80, 8'h80, 8'h81, 8'h80, 8'h80};
        logic [23:0] t_mb[5] = '{24'h800000, 24'h900000, 24'h800001, 24'h800000, 24'h800000};
        logic        w_sw[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0]  w_e[5]  = '{8'h80, 8'h80, 8'h90, 8'hA8, 8'h9A};
        logic [26:0] w_sm[5] = '{27'h4000000, 27'h2000000, 27'h0000801, 27'h0000001, 27'h0000001};
        int          w_lat[5] = '{1, 2, 5, 1, 8};
        for (int i = 0; i < 5; i++) begin
            run_op(t_ea[i], t_ma[i], t_eb[i], t_mb[i], 0, sw, e, big, sm, lat);
            vectors++;
            if ({sw, e, sm} !== {w_sw[i], w_e[i], w_sm[i]} || lat != w_lat[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got sw=%b e=%h sm=%h lat=%0d want sw=%b e=%h sm=%h lat=%0d",
                         i, sw, e, sm, lat, w_sw[i], w_e[i], w_sm[i], w_lat[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic sw; logic [7:0] e; logic [23:0] big; logic [26:0] sm; int lat;
        run_op(8'h85, 24'hABCDEF, 8'h80, 24'hFFFFFF, 5, sw, e, big, sm, lat);
    endtask

    task automatic test_random(input int count);
        logic sw; logic [7:0] e; logic [23:0] big; logic [26:0] sm; int lat;
        logic [7:0] ea, eb; logic [23:0] ma, mb; int delta;
        for (int i = 0; i < count; i++) begin
            ea    = 8'($urandom_range(50, 205));
            delta = $urandom_range(0, 45);
            eb    = ($urandom_range(0, 1) == 1) ? ea + 8'(delta) : ea - 8'(delta);
            ma    = {1'b1, 23'($urandom)};
            mb    = ($urandom_range(0, 7) == 0) ? ma : {1'b1, 23'($urandom)};
            run_op(ea, ma, eb, mb, $urandom_range(0, 3), sw, e, big, sm, lat);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic sw; logic [7:0] e; logic [23:0] big; logic [26:0] sm; int lat;
        exp_a = 8'h94; mant_a = 24'hC00000; exp_b = 8'h80; mant_b = 24'hFFFFFF;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, exp_out, mant_big, mant_small, swapped} !== {2'b10, 8'd0, 24'd0, 27'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_shift: got r=%b v=%b e=%h big=%h sm=%h sw=%b want r=1 v=0 all 0",
                     in_ready, out_valid, exp_out, mant_big, mant_small, swapped);
        end
        #3 rst = 1'b0;
        run_op(8'h80, 24'h812345, 8'h94, 24'hFEDCBA, 0, sw, e, big, sm, lat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random(60);
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
